// File: rtl/branch_predecode_ras.sv
// branch_predecode_ras
//   Fetch-stage predecoder for a packet of FETCH_WIDTH MIPS instructions.
//   Finds the first control-flow instruction among the valid slots and
//   computes its static prediction: backward branches taken, direct jumps
//   taken, returns taken from the return address stack. The prediction is
//   registered, so it appears one cycle after the packet is accepted. A
//   circular RAS tracks calls and returns. Its top pointer and occupancy are
//   exported with each prediction so that misprediction repair can restore them.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   fetch_valid     packet present
//   fetch_pc        address of slot 0 (slot i lives at fetch_pc + 4*i)
//   fetch_instr     slot i at bits [32i+31:32i]
//   fetch_mask      per-slot valid
//   stall           hold outputs and RAS, ignore the packet
//   flush           drop the in-flight prediction, RAS unchanged
//   restore_valid   reload RAS top/count from restore_ptr/restore_count
//   pred_*          registered prediction for the last accepted packet
//   pred_ras_ptr    RAS top before that packet's update (checkpoint)
//   pred_ras_count  RAS occupancy before that packet's update (checkpoint)
module branch_predecode_ras #(
    parameter  int FETCH_WIDTH = 2,
    parameter  int RAS_DEPTH   = 8,
    localparam int PTR_W       = $clog2(RAS_DEPTH),
    localparam int SLOT_W      = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fetch_valid,
    input  logic [31:0]               fetch_pc,
    input  logic [32*FETCH_WIDTH-1:0] fetch_instr,
    input  logic [FETCH_WIDTH-1:0]    fetch_mask,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      restore_valid,
    input  logic [PTR_W-1:0]          restore_ptr,
    input  logic [PTR_W:0]            restore_count,
    output logic                      pred_valid,
    output logic [SLOT_W-1:0]         pred_slot,
    output logic [1:0]                pred_kind,
    output logic                      pred_taken,
    output logic [31:0]               pred_target,
    output logic                      pred_ras_miss,
    output logic [PTR_W-1:0]          pred_ras_ptr,
    output logic [PTR_W:0]            pred_ras_count
);

    localparam logic [1:0] KIND_BRANCH = 2'd0;
    localparam logic [1:0] KIND_JUMP_I = 2'd1;
    localparam logic [1:0] KIND_JUMP_R = 2'd2;
    localparam logic [1:0] KIND_RETURN = 2'd3;

    // ------------------------------------------------------------------
    // Instruction classification
    // ------------------------------------------------------------------
    function automatic logic dec_jump_r(input logic [31:0] ins);
        return (ins[31:26] == 6'b000000) && (ins[5:1] == 5'b00100);
    endfunction

    function automatic logic dec_jump_i(input logic [31:0] ins);
        return ins[31:27] == 5'b00001;
    endfunction

    // BEQ/BNE/BLEZ/BGTZ, plus the REGIMM family BLTZ/BGEZ/BLTZAL/BGEZAL
    function automatic logic dec_branch(input logic [31:0] ins);
        return (ins[31:28] == 4'b0001) ||
               ((ins[31:26] == 6'b000001) && (ins[19:17] == 3'b000));
    endfunction

    function automatic logic dec_call(input logic [31:0] ins);
        return (dec_jump_r(ins) && (ins[15:11] == 5'd31)) ||
               (ins[31:26] == 6'b000011) ||
               ((ins[31:26] == 6'b000001) && (ins[20:17] == 4'b1000));
    endfunction

    function automatic logic dec_return(input logic [31:0] ins);
        return ((ins[31:21] == 11'b000000_11111) && (ins[5:0] == 6'b001000)) ||
               (dec_jump_r(ins) && (ins[25:21] == 5'd31));
    endfunction

    function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                  input logic [31:0] ins);
        logic signed [31:0] offset;
        offset = {{14{ins[15]}}, ins[15:0], 2'b00};
        return pc + 32'd4 + 32'(offset);
    endfunction

    function automatic logic [31:0] jump_target(input logic [31:0] pc,
                                                input logic [31:0] ins);
        logic [31:0] seq_pc;
        seq_pc = pc + 32'd4;
        return {seq_pc[31:28], ins[25:0], 2'b00};
    endfunction

    // Occupancy saturates at RAS_DEPTH; the oldest entry is overwritten.
    function automatic logic [PTR_W:0] sat_inc(input logic [PTR_W:0] count);
        if (count == (PTR_W+1)'(RAS_DEPTH)) begin
            return count;
        end
        return count + (PTR_W+1)'(1);
    endfunction

    // RAS state
    logic [PTR_W-1:0] ras_top;
    logic [PTR_W:0]   ras_count;
    logic [31:0]      ras_mem [RAS_DEPTH];

    // Stage p0: combinational slot selection and target computation
    logic              hit_p0;
    logic [SLOT_W-1:0] slot_p0;
    logic [31:0]       instr_p0;
    logic [31:0]       pc_p0;
    logic              is_call_p0;
    logic              is_ret_p0;
    logic [1:0]        kind_p0;
    logic              taken_p0;
    logic [31:0]       target_p0;
    logic              miss_p0;
    logic [31:0]       link_p0;
    logic [PTR_W-1:0]  top_inc_p0;

    // Lowest-index valid control-flow slot wins
    always_comb begin
        hit_p0   = 1'b0;
        slot_p0  = '0;
        instr_p0 = '0;
        pc_p0    = fetch_pc;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            if (!hit_p0 && fetch_mask[i] &&
                (dec_branch(fetch_instr[32*i +: 32]) ||
                 dec_jump_i(fetch_instr[32*i +: 32]) ||
                 dec_jump_r(fetch_instr[32*i +: 32]))) begin
                hit_p0   = 1'b1;
                slot_p0  = SLOT_W'(i);
                instr_p0 = fetch_instr[32*i +: 32];
                pc_p0    = fetch_pc + 32'(4 * i);
            end
        end
    end

    always_comb begin
        is_call_p0 = hit_p0 && dec_call(instr_p0);
        is_ret_p0  = hit_p0 && dec_return(instr_p0);
        link_p0    = pc_p0 + 32'd8;
        top_inc_p0 = ras_top + PTR_W'(1);
        kind_p0    = KIND_BRANCH;
        taken_p0   = 1'b0;
        target_p0  = '0;
        miss_p0    = 1'b0;
        if (dec_branch(instr_p0)) begin
            kind_p0   = KIND_BRANCH;
            taken_p0  = instr_p0[15];
            target_p0 = branch_target(pc_p0, instr_p0);
        end else if (dec_jump_i(instr_p0)) begin
            kind_p0   = KIND_JUMP_I;
            taken_p0  = 1'b1;
            target_p0 = jump_target(pc_p0, instr_p0);
        end else if (is_ret_p0) begin
            kind_p0 = KIND_RETURN;
            if (ras_count != '0) begin
                taken_p0  = 1'b1;
                target_p0 = ras_mem[ras_top];
            end else begin
                miss_p0 = 1'b1;
            end
        end else if (dec_jump_r(instr_p0)) begin
            kind_p0 = KIND_JUMP_R;
        end
    end

    // Stage p1: registered prediction and RAS update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pred_valid     <= 1'b0;
            pred_slot      <= '0;
            pred_kind      <= '0;
            pred_taken     <= 1'b0;
            pred_target    <= '0;
            pred_ras_miss  <= 1'b0;
            pred_ras_ptr   <= '0;
            pred_ras_count <= '0;
            ras_top        <= '0;
            ras_count      <= '0;
            for (int e = 0; e < RAS_DEPTH; e++) begin
                ras_mem[e] <= '0;
            end
        end else if (restore_valid) begin
            // Repair overrides stall; entry contents stay as they are
            ras_top    <= restore_ptr;
            ras_count  <= restore_count;
            pred_valid <= 1'b0;
        end else if (flush) begin
            pred_valid <= 1'b0;
        end else if (!stall) begin
            if (fetch_valid) begin
                pred_valid     <= hit_p0;
                pred_slot      <= slot_p0;
                pred_kind      <= kind_p0;
                pred_taken     <= taken_p0;
                pred_target    <= target_p0;
                pred_ras_miss  <= miss_p0;
                pred_ras_ptr   <= ras_top;
                pred_ras_count <= ras_count;
                if (is_call_p0 && is_ret_p0) begin
                    // JALR $31,$31: target already read from the old top,
                    // now replace that entry in place
                    ras_mem[ras_top] <= link_p0;
                    if (ras_count == '0) begin
                        ras_count <= (PTR_W+1)'(1);
                    end
                end else if (is_call_p0) begin
                    ras_top             <= top_inc_p0;
                    ras_mem[top_inc_p0] <= link_p0;
                    ras_count           <= sat_inc(ras_count);
                end else if (is_ret_p0 && (ras_count != '0)) begin
                    ras_top   <= ras_top - PTR_W'(1);
                    ras_count <= ras_count - (PTR_W+1)'(1);
                end
            end else begin
                pred_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_branch_predecode_ras.sv
// Randomized and directed bench for branch_predecode_ras with a behavioural
// reference model of the decoder rules and a circular return stack.
module tb_branch_predecode_ras;

    localparam int FW    = 2;
    localparam int DEPTH = 8;
    localparam int PW    = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic           fetch_valid;
    logic [31:0]    fetch_pc;
    logic [32*FW-1:0] fetch_instr;
    logic [FW-1:0]  fetch_mask;
    logic           stall;
    logic           flush;
    logic           restore_valid;
    logic [PW-1:0]  restore_ptr;
    logic [PW:0]    restore_count;
    logic           pred_valid;
    logic [0:0]     pred_slot;
    logic [1:0]     pred_kind;
    logic           pred_taken;
    logic [31:0]    pred_target;
    logic           pred_ras_miss;
    logic [PW-1:0]  pred_ras_ptr;
    logic [PW:0]    pred_ras_count;

    branch_predecode_ras #(.FETCH_WIDTH(FW), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .fetch_instr(fetch_instr), .fetch_mask(fetch_mask), .stall(stall),
        .flush(flush), .restore_valid(restore_valid), .restore_ptr(restore_ptr),
        .restore_count(restore_count), .pred_valid(pred_valid),
        .pred_slot(pred_slot), .pred_kind(pred_kind), .pred_taken(pred_taken),
        .pred_target(pred_target), .pred_ras_miss(pred_ras_miss),
        .pred_ras_ptr(pred_ras_ptr), .pred_ras_count(pred_ras_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Reference model state
    int          m_top, m_cnt;
    logic [31:0] m_ras [DEPTH];
    bit          e_valid, e_taken, e_miss;
    int          e_slot, e_kind, e_ptr, e_cnt;
    logic [31:0] e_target;

    task automatic model_reset();
        m_top = 0; m_cnt = 0;
        for (int k = 0; k < DEPTH; k++) m_ras[k] = 32'h0;
        e_valid = 0; e_taken = 0; e_miss = 0;
        e_slot = 0; e_kind = 0; e_ptr = 0; e_cnt = 0; e_target = 32'h0;
    endtask

    task automatic model_step();
        logic [31:0] ins, pc;
        int op, fn, rs, rt, rd, simm;
        bit jr, ji, br, call, ret;
        if (restore_valid) begin
            m_top = int'(restore_ptr); m_cnt = int'(restore_count); e_valid = 0;
        end else if (flush) begin
            e_valid = 0;
        end else if (!stall) begin
            e_valid = 0;
            if (fetch_valid) begin
                for (int s = 0; s < FW; s++) begin
                    if (!e_valid && fetch_mask[s]) begin
                        ins = fetch_instr[32*s +: 32];
                        pc  = fetch_pc + 32'(4 * s);
                        op = int'(ins >> 26); fn = int'(ins & 32'h3F);
                        rs = int'((ins >> 21) & 32'h1F); rt = int'((ins >> 16) & 32'h1F);
                        rd = int'((ins >> 11) & 32'h1F);
                        jr = (op == 0) && (fn == 8 || fn == 9);
                        ji = (op == 2) || (op == 3);
                        br = (op >= 4 && op <= 7) || (op == 1 && (rt & 14) == 0);
                        call = (jr && rd == 31) || op == 3 || (op == 1 && (rt >> 1) == 8);
                        ret  = jr && rs == 31;
                        if (br || ji || jr) begin
                            e_valid = 1; e_slot = s; e_ptr = m_top; e_cnt = m_cnt;
                            e_taken = 0; e_target = 32'h0; e_miss = 0;
                            if (br) begin
                                simm = int'(ins & 32'hFFFF);
                                if (simm >= 32768) simm -= 65536;
                                e_kind = 0; e_taken = simm < 0;
                                e_target = pc + 32'd4 + 32'(simm * 4);
                            end else if (ji) begin
                                e_kind = 1; e_taken = 1;
                                e_target = ((pc + 32'd4) & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
                            end else if (ret) begin
                                e_kind = 3;
                                if (m_cnt > 0) begin e_taken = 1; e_target = m_ras[m_top]; end
                                else e_miss = 1;
                            end else begin
                                e_kind = 2;
                            end
                            if (call && ret) begin
                                m_ras[m_top] = pc + 32'd8;
                                if (m_cnt == 0) m_cnt = 1;
                            end else if (call) begin
                                m_top = (m_top + 1) % DEPTH;
                                m_ras[m_top] = pc + 32'd8;
                                if (m_cnt < DEPTH) m_cnt++;
                            end else if (ret && m_cnt > 0) begin
                                m_top = (m_top + DEPTH - 1) % DEPTH;
                                m_cnt--;
                            end
                        end
                    end
                end
            end
        end
    endtask

    task automatic compare_all();
        check("pred_valid", 32'(pred_valid), 32'(e_valid));
        if (e_valid) begin
            check("pred_slot", 32'(pred_slot), 32'(e_slot));
            check("pred_kind", 32'(pred_kind), 32'(e_kind));
            check("pred_taken", 32'(pred_taken), 32'(e_taken));
            check("pred_target", pred_target, e_target);
            check("pred_ras_miss", 32'(pred_ras_miss), 32'(e_miss));
            check("pred_ras_ptr", 32'(pred_ras_ptr), 32'(e_ptr));
            check("pred_ras_count", 32'(pred_ras_count), 32'(e_cnt));
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic pkt(input logic [31:0] pc, input logic [31:0] i0,
                       input logic [31:0] i1, input logic [1:0] m);
        fetch_valid = 1'b1; fetch_pc = pc; fetch_instr = {i1, i0}; fetch_mask = m;
        cycle();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, 32'(pred_valid), 32'h0);
        check({tag, "_slot"}, 32'(pred_slot), 32'h0);
        check({tag, "_kind"}, 32'(pred_kind), 32'h0);
        check({tag, "_taken"}, 32'(pred_taken), 32'h0);
        check({tag, "_target"}, pred_target, 32'h0);
        check({tag, "_miss"}, 32'(pred_ras_miss), 32'h0);
        check({tag, "_ptr"}, 32'(pred_ras_ptr), 32'h0);
        check({tag, "_count"}, 32'(pred_ras_count), 32'h0);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 10))
            0: return {6'd0, w[25:6], 6'h20};
            1: return {6'h04, w[25:0]};
            2: return {6'h05, w[25:0]};
            3: return {6'h01, w[25:21], w[20], 3'b000, w[16], w[15:0]};
            4: return {6'h02, w[25:0]};
            5: return {6'h03, w[25:0]};
            6: return 32'h03E0_0008;
            7: return {6'd0, w[25:21], 15'd0, 6'h08};
            8: return {6'd0, w[25:21], 5'd0, 5'd31, 5'd0, 6'h09};
            9: return 32'h03E0_F809;
            default: return w;
        endcase
    endfunction

    logic [PW-1:0] cap_ptr;
    logic [PW:0]   cap_cnt;
    int            r;

    initial begin
        rst = 1'b1; fetch_valid = 0; fetch_pc = 0; fetch_instr = 0; fetch_mask = 0;
        stall = 0; flush = 0; restore_valid = 0; restore_ptr = 0; restore_count = 0;
        model_reset();
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // Call then return
        pkt(32'h8000_0000, 32'h0C00_0040, 32'h0, 2'b01);
        check("jal_valid", 32'(pred_valid), 32'h1);
        check("jal_kind", 32'(pred_kind), 32'h1);
        check("jal_target", pred_target, 32'h8000_0100);
        pkt(32'h8000_0008, 32'h03E0_0008, 32'h0, 2'b01);
        check("ret_kind", 32'(pred_kind), 32'h3);
        check("ret_target", pred_target, 32'h8000_0008);
        check("ret_count_before", 32'(pred_ras_count), 32'h1);

        // Branches
        pkt(32'h8000_0010, 32'h0, 32'h1000_FFFF, 2'b11);
        check("beq_slot", 32'(pred_slot), 32'h1);
        check("beq_taken", 32'(pred_taken), 32'h1);
        check("beq_target", pred_target, 32'h8000_0014);
        check("count_after_ret", 32'(pred_ras_count), 32'h0);
        pkt(32'h8000_0020, 32'h1420_0004, 32'h0, 2'b11);
        check("bne_taken", 32'(pred_taken), 32'h0);
        check("bne_target", pred_target, 32'h8000_0034);

        // Masked call must not push
        pkt(32'h8000_0030, 32'h0C00_0001, 32'h1000_0001, 2'b10);
        check("masked_slot", 32'(pred_slot), 32'h1);

        // Overflow: nine calls, eight returns, one miss
        for (int k = 0; k < 9; k++)
            pkt(32'h8000_1000 + 32'(16 * k), 32'h0C00_0000 + 32'(k), 32'h0, 2'b01);
        for (int j = 0; j < 8; j++) begin
            pkt(32'h8000_2000 + 32'(16 * j), 32'h03E0_0008, 32'h0, 2'b01);
            check("ovf_ret_target", pred_target, 32'h8000_1000 + 32'(16 * (8 - j)) + 32'd8);
        end
        pkt(32'h8000_2100, 32'h03E0_0008, 32'h0, 2'b01);
        check("ovf_miss", 32'(pred_ras_miss), 32'h1);
        check("ovf_miss_taken", 32'(pred_taken), 32'h0);

        // Checkpoint repair
        pkt(32'h8000_3000, 32'h0C00_0100, 32'h0, 2'b01);
        pkt(32'h8000_3010, 32'h0C00_0100, 32'h0, 2'b01);
        pkt(32'h8000_3020, 32'h0C00_0100, 32'h0, 2'b01);
        cap_ptr = pred_ras_ptr; cap_cnt = pred_ras_count;
        pkt(32'h8000_3030, 32'h0C00_0100, 32'h0, 2'b01);
        fetch_valid = 1'b0; restore_valid = 1'b1; restore_ptr = cap_ptr; restore_count = cap_cnt;
        cycle();
        restore_valid = 1'b0;
        check("restore_valid_clear", 32'(pred_valid), 32'h0);
        pkt(32'h8000_3100, 32'h03E0_0008, 32'h0, 2'b01);
        check("restore_ret_target", pred_target, 32'h8000_3018);

        // Stall holds everything
        pkt(32'h8000_4000, 32'h0C00_0123, 32'h0, 2'b01);
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            pkt(32'h8000_5000 + 32'(8 * k), $urandom, $urandom, 2'b11);
            check("stall_target", pred_target, 32'h8000_048C);
        end
        stall = 1'b0;

        // Flush drops a call without pushing
        flush = 1'b1;
        pkt(32'h8000_4100, 32'h0C00_0200, 32'h0, 2'b01);
        flush = 1'b0;
        check("flush_valid", 32'(pred_valid), 32'h0);
        pkt(32'h8000_4200, 32'h03E0_0008, 32'h0, 2'b01);
        check("flush_ret_target", pred_target, 32'h8000_4008);

        // Restore wins over stall
        stall = 1'b1; restore_valid = 1'b1; restore_ptr = 3'd5; restore_count = 4'd2;
        pkt(32'h8000_4300, 32'h0C00_0200, 32'h0, 2'b01);
        stall = 1'b0; restore_valid = 1'b0;
        pkt(32'h8000_4400, 32'h03E0_0008, 32'h0, 2'b01);
        check("rs_ptr", 32'(pred_ras_ptr), 32'h5);
        check("rs_count", 32'(pred_ras_count), 32'h2);

        // JALR $31,$31 swaps the top entry
        pkt(32'h8000_00F8, 32'h0C00_0000, 32'h0, 2'b01);
        pkt(32'h8000_0040, 32'h03E0_F809, 32'h0, 2'b01);
        check("jalr_kind", 32'(pred_kind), 32'h3);
        check("jalr_target", pred_target, 32'h8000_0100);
        pkt(32'h8000_0050, 32'h03E0_0008, 32'h0, 2'b01);
        check("jalr_ret_target", pred_target, 32'h8000_0048);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            restore_valid = (r < 4);
            flush         = (r >= 4 && r < 9);
            stall         = (r >= 9 && r < 20) || ($urandom_range(0, 19) == 0);
            restore_ptr   = PW'($urandom_range(0, DEPTH - 1));
            restore_count = (PW+1)'($urandom_range(0, DEPTH));
            fetch_valid   = ($urandom_range(0, 19) != 0);
            fetch_pc      = $urandom & 32'hFFFF_FFF8;
            fetch_instr   = {rand_instr(), rand_instr()};
            fetch_mask    = FW'($urandom);
            cycle();
        end
        restore_valid = 0; flush = 0; stall = 0;

        // Asynchronous reset mid-stream
        pkt(32'h8000_6000, 32'h0C00_0300, 32'h0, 2'b01);
        #2;
        rst = 1'b1;
        #1;
        check_zero_outputs("midrst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        pkt(32'h8000_7000, 32'h03E0_0008, 32'h0, 2'b01);
        check("post_rst_miss", 32'(pred_ras_miss), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
